// File: rtl/rtl_constants.sv
// Shared constants and FSM encoding for the branch RAT copy register controller.
// Imported by bratcr_ctrl and bratcr_age_cmp.
package rtl_constants;

    localparam int BRATCR_NUM_ETY       = 4;
    localparam int BRATCR_NUM_ETY_CLOG  = $clog2(BRATCR_NUM_ETY);
    localparam int RESTORE_ROWS_PER_CYC = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } bratcr_fsm_e;

endpackage

// File: rtl/bratcr_age_cmp.sv
// Wrap-around ROB age comparator: a_younger is set when robid_a was allocated
// after robid_b, both measured as distance from the ROB head.
module bratcr_age_cmp #(
    parameter int ROB_SIZE_CLOG = 5
) (
    input  logic [ROB_SIZE_CLOG-1:0] robid_a,
    input  logic [ROB_SIZE_CLOG-1:0] robid_b,
    input  logic [ROB_SIZE_CLOG-1:0] head,
    output logic                     a_younger
);

    logic [ROB_SIZE_CLOG-1:0] w_age_a;
    logic [ROB_SIZE_CLOG-1:0] w_age_b;

    assign w_age_a   = robid_a - head;
    assign w_age_b   = robid_b - head;
    assign a_younger = (w_age_a > w_age_b);

endmodule

// File: rtl/bratcr_ctrl.sv
// BRATCR controller: checkpoint slot allocation/free, mispredict squash and
// multi-cycle FRAT restore sequencing. Optional macro BRATCR_STATS_EN adds stall/mispredict counters.
module bratcr_ctrl #(
    parameter int ISSUE_WIDTH_MAX      = 2,
    parameter int ROB_MAX_RETIRE       = 2,
    parameter int BRATCR_NUM_ETY       = rtl_constants::BRATCR_NUM_ETY,
    parameter int ROB_SIZE_CLOG        = 5,
    parameter int RAT_SIZE             = 32,
    parameter int RESTORE_ROWS_PER_CYC = rtl_constants::RESTORE_ROWS_PER_CYC
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                         br_val_id,
    input  logic [ROB_SIZE_CLOG-1:0]                           rob_is_ptr,
    input  logic [ROB_SIZE_CLOG-1:0]                           rob_head_ptr,
    input  logic [ROB_MAX_RETIRE-1:0]                          ret_br_val,
    input  logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0]            robid_ret,
    input  logic                                               mispredict_val,
    input  logic [ROB_SIZE_CLOG-1:0]                           mispredict_robid,
    output logic [ISSUE_WIDTH_MAX-1:0]                         ckpt_save_we,
    output logic [ISSUE_WIDTH_MAX*$clog2(BRATCR_NUM_ETY)-1:0]  ckpt_save_idx,
    output logic                                               restore_we,
    output logic [$clog2(BRATCR_NUM_ETY)-1:0]                  restore_idx,
    output logic [$clog2(RAT_SIZE)-1:0]                        restore_row_base,
    output logic                                               rename_stall,
    output logic [$clog2(BRATCR_NUM_ETY):0]                    ckpt_free_cnt,
    output logic                                               mispredict_miss
`ifdef BRATCR_STATS_EN
    ,
    output logic [31:0]                                        stat_stall_cycles,
    output logic [15:0]                                        stat_mispredicts
`endif
);

    import rtl_constants::*;

    localparam int SLOT_W = $clog2(BRATCR_NUM_ETY);
    localparam int ROW_W  = $clog2(RAT_SIZE);
    localparam int ROWS   = RAT_SIZE / RESTORE_ROWS_PER_CYC;
    localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    bratcr_fsm_e                r_state, w_state_nxt;
    logic [BRATCR_NUM_ETY-1:0]  r_valid, w_valid_nxt;
    logic [ROB_SIZE_CLOG-1:0]   r_robid     [BRATCR_NUM_ETY];
    logic [ROB_SIZE_CLOG-1:0]   w_robid_nxt [BRATCR_NUM_ETY];
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [SLOT_W-1:0]          r_ridx, w_ridx_nxt;
    logic [ROB_SIZE_CLOG-1:0]   r_rest_robid, w_rest_robid_nxt;
    logic [SLOT_W:0]            r_free_cnt;

    logic [BRATCR_NUM_ETY-1:0]  w_slot_younger;
    logic                       w_cur_younger;
    logic                       w_hit;
    logic [SLOT_W-1:0]          w_hit_idx;
    logic                       w_accept;
    logic [BRATCR_NUM_ETY-1:0]  w_ret_clr;
    logic [BRATCR_NUM_ETY-1:0]  w_sq_clr;
    logic                       w_fits;
    logic                       w_alloc_ok;
    logic [SLOT_W-1:0]          w_lane_idx [ISSUE_WIDTH_MAX];

    function automatic logic [SLOT_W:0] f_free_cnt(input logic [BRATCR_NUM_ETY-1:0] v);
        f_free_cnt = '0;
        for (int s = 0; s < BRATCR_NUM_ETY; s++) begin
            f_free_cnt = f_free_cnt + {{SLOT_W{1'b0}}, ~v[s]};
        end
    endfunction

    // Each slot is judged against the mispredicted branch; one extra comparator
    // decides whether a new mispredict is older than the restore in progress.
    for (genvar g = 0; g < BRATCR_NUM_ETY; g++) begin : g_age
        bratcr_age_cmp #(.ROB_SIZE_CLOG(ROB_SIZE_CLOG)) u_age_cmp (
            .robid_a   (r_robid[g]),
            .robid_b   (mispredict_robid),
            .head      (rob_head_ptr),
            .a_younger (w_slot_younger[g])
        );
    end

    bratcr_age_cmp #(.ROB_SIZE_CLOG(ROB_SIZE_CLOG)) u_age_cmp_rest (
        .robid_a   (r_rest_robid),
        .robid_b   (mispredict_robid),
        .head      (rob_head_ptr),
        .a_younger (w_cur_younger)
    );

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int s = BRATCR_NUM_ETY - 1; s >= 0; s--) begin
            if (r_valid[s] && (r_robid[s] == mispredict_robid)) begin
                w_hit     = 1'b1;
                w_hit_idx = SLOT_W'(s);
            end
        end
    end

    assign w_accept = mispredict_val && w_hit && ((r_state == IDLE) || w_cur_younger);

    always_comb begin
        w_ret_clr = '0;
        w_sq_clr  = '0;
        for (int s = 0; s < BRATCR_NUM_ETY; s++) begin
            for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
                if (ret_br_val[k] && r_valid[s] &&
                    (r_robid[s] == robid_ret[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG])) begin
                    w_ret_clr[s] = 1'b1;
                end
            end
            if (w_accept && r_valid[s] &&
                ((SLOT_W'(s) == w_hit_idx) || w_slot_younger[s])) begin
                w_sq_clr[s] = 1'b1;
            end
        end
    end

    always_comb begin
        int v_req;
        v_req = 0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            v_req = v_req + int'(br_val_id[i]);
        end
        w_fits = (v_req <= int'(r_free_cnt));
    end

    assign w_alloc_ok = (r_state == IDLE) && !mispredict_val && w_fits;

    // Lanes take the lowest free slots in lane order; only registered valids are considered.
    always_comb begin
        logic [BRATCR_NUM_ETY-1:0] v_taken;
        logic                      v_found;
        v_taken = '0;
        v_found = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            w_lane_idx[i] = '0;
            v_found       = 1'b0;
            if (br_val_id[i]) begin
                for (int s = 0; s < BRATCR_NUM_ETY; s++) begin
                    if (!v_found && !r_valid[s] && !v_taken[s]) begin
                        v_found       = 1'b1;
                        v_taken[s]    = 1'b1;
                        w_lane_idx[i] = SLOT_W'(s);
                    end
                end
            end
        end
    end

    always_comb begin
        w_valid_nxt = r_valid & ~w_ret_clr & ~w_sq_clr;
        w_robid_nxt = r_robid;
        if (w_alloc_ok) begin
            for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
                if (br_val_id[i]) begin
                    w_valid_nxt[w_lane_idx[i]] = 1'b1;
                    w_robid_nxt[w_lane_idx[i]] = rob_is_ptr + ROB_SIZE_CLOG'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ridx_nxt       = r_ridx;
        w_rest_robid_nxt = r_rest_robid;
        if (w_accept) begin
            w_state_nxt      = RESTORE;
            w_cnt_nxt        = '0;
            w_ridx_nxt       = w_hit_idx;
            w_rest_robid_nxt = mispredict_robid;
        end else if (r_state == RESTORE) begin
            if (r_cnt == CNT_W'(ROWS - 1)) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ridx       <= '0;
            r_rest_robid <= '0;
            r_valid      <= '0;
            r_free_cnt   <= (SLOT_W+1)'(BRATCR_NUM_ETY);
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ridx       <= w_ridx_nxt;
            r_rest_robid <= w_rest_robid_nxt;
            r_valid      <= w_valid_nxt;
            r_free_cnt   <= f_free_cnt(w_valid_nxt);
        end
    end

    // Slot robids are qualified by r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        r_robid <= w_robid_nxt;
    end

    always_comb begin
        ckpt_save_we = '0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            ckpt_save_idx[i*SLOT_W +: SLOT_W] = w_lane_idx[i];
        end
        if (!rst && w_alloc_ok) begin
            ckpt_save_we = br_val_id;
        end
    end

    assign restore_we       = !rst && (r_state == RESTORE);
    assign restore_idx      = restore_we ? r_ridx : '0;
    assign restore_row_base = restore_we ? ROW_W'(int'(r_cnt) * RESTORE_ROWS_PER_CYC) : '0;
    assign rename_stall     = !rst && ((r_state == RESTORE) ||
                              ((|br_val_id) && (mispredict_val || !w_fits)));
    assign ckpt_free_cnt    = r_free_cnt;
    assign mispredict_miss  = !rst && mispredict_val && !w_accept;

`ifdef BRATCR_STATS_EN
    logic [31:0] r_stat_stall;
    logic [15:0] r_stat_mp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_stall <= '0;
            r_stat_mp    <= '0;
        end else begin
            if (rename_stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 1'b1;
            if (w_accept && (r_stat_mp != '1))        r_stat_mp    <= r_stat_mp + 1'b1;
        end
    end

    assign stat_stall_cycles = r_stat_stall;
    assign stat_mispredicts  = r_stat_mp;
`endif

endmodule

// File: tb/tb_bratcr_ctrl.sv
// Self-checking bench for bratcr_ctrl: directed scenarios followed by random
// traffic, all compared against a slot-list reference model.
module tb_bratcr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  br_val_id;
    logic [4:0]  rob_is_ptr;
    logic [4:0]  rob_head_ptr;
    logic [1:0]  ret_br_val;
    logic [9:0]  robid_ret;
    logic        mispredict_val;
    logic [4:0]  mispredict_robid;
    logic [1:0]  ckpt_save_we;
    logic [3:0]  ckpt_save_idx;
    logic        restore_we;
    logic [1:0]  restore_idx;
    logic [4:0]  restore_row_base;
    logic        rename_stall;
    logic [2:0]  ckpt_free_cnt;
    logic        mispredict_miss;
`ifdef BRATCR_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [15:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    bratcr_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .br_val_id        (br_val_id),
        .rob_is_ptr       (rob_is_ptr),
        .rob_head_ptr     (rob_head_ptr),
        .ret_br_val       (ret_br_val),
        .robid_ret        (robid_ret),
        .mispredict_val   (mispredict_val),
        .mispredict_robid (mispredict_robid),
        .ckpt_save_we     (ckpt_save_we),
        .ckpt_save_idx    (ckpt_save_idx),
        .restore_we       (restore_we),
        .restore_idx      (restore_idx),
        .restore_row_base (restore_row_base),
        .rename_stall     (rename_stall),
        .ckpt_free_cnt    (ckpt_free_cnt),
        .mispredict_miss  (mispredict_miss)
`ifdef BRATCR_STATS_EN
        ,
        .stat_stall_cycles(stat_stall_cycles),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: list of checkpoint slots plus restore progress.
    bit m_v   [4];
    int m_rob [4];
    bit m_rest;
    int m_row;
    int m_ridx;
    int m_rest_rob;
    int m_stall_cnt;
    int m_mp_cnt;

    bit e_accept;
    bit e_alloc;
    int e_hit;
    int e_slot [2];

    logic [1:0] s_we;
    logic [3:0] s_idx;
    logic       s_stall, s_rwe, s_miss;
    logic [1:0] s_ridx;
    logic [4:0] s_rbase;
    logic [2:0] s_free;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int age(input int x);
        return (x - int'(rob_head_ptr)) & 31;
    endfunction

    task automatic mreset();
        for (int s = 0; s < 4; s++) begin
            m_v[s]   = 1'b0;
            m_rob[s] = 0;
        end
        m_rest      = 1'b0;
        m_row       = 0;
        m_ridx      = 0;
        m_rest_rob  = 0;
        m_stall_cnt = 0;
        m_mp_cnt    = 0;
    endtask

    task automatic idle_in();
        br_val_id        = 2'b00;
        ret_br_val       = 2'b00;
        robid_ret        = '0;
        mispredict_val   = 1'b0;
        mispredict_robid = '0;
    endtask

    task automatic model_check();
        int free, nreq, rank;
        int fl[$];
        bit exp_stall;
        free = 0;
        fl.delete();
        for (int s = 0; s < 4; s++) begin
            if (!m_v[s]) begin
                free++;
                fl.push_back(s);
            end
        end
        nreq  = int'(br_val_id[0]) + int'(br_val_id[1]);
        e_hit = -1;
        for (int s = 3; s >= 0; s--) begin
            if (m_v[s] && m_rob[s] == int'(mispredict_robid)) e_hit = s;
        end
        e_accept = mispredict_val && (e_hit >= 0) &&
                   (!m_rest || age(int'(mispredict_robid)) < age(m_rest_rob));
        e_alloc  = !m_rest && !mispredict_val && (nreq <= free);
        rank = 0;
        e_slot[0] = 0;
        e_slot[1] = 0;
        for (int i = 0; i < 2; i++) begin
            if (e_alloc && br_val_id[i]) begin
                e_slot[i] = fl[rank];
                rank++;
            end
        end
        exp_stall = m_rest || ((br_val_id != 2'b00) && (mispredict_val || nreq > free));

        s_we    = ckpt_save_we;
        s_idx   = ckpt_save_idx;
        s_stall = rename_stall;
        s_rwe   = restore_we;
        s_ridx  = restore_idx;
        s_rbase = restore_row_base;
        s_miss  = mispredict_miss;
        s_free  = ckpt_free_cnt;

        chk("free_cnt", ckpt_free_cnt, free);
        chk("save_we", ckpt_save_we, e_alloc ? br_val_id : 2'b00);
        for (int i = 0; i < 2; i++) begin
            if (e_alloc && br_val_id[i]) chk("save_idx", ckpt_save_idx[i*2 +: 2], e_slot[i]);
        end
        chk("rename_stall", rename_stall, exp_stall);
        chk("restore_we", restore_we, m_rest);
        chk("restore_idx", restore_idx, m_rest ? m_ridx : 0);
        chk("row_base", restore_row_base, m_rest ? m_row * 8 : 0);
        chk("mp_miss", mispredict_miss, mispredict_val && !e_accept);
    endtask

    task automatic model_adv();
        bit nv[4];
        for (int s = 0; s < 4; s++) begin
            nv[s] = m_v[s];
            for (int k = 0; k < 2; k++) begin
                if (m_v[s] && ret_br_val[k] && int'(robid_ret[k*5 +: 5]) == m_rob[s]) nv[s] = 1'b0;
            end
        end
        if (s_stall) m_stall_cnt++;
        if (e_accept) begin
            for (int s = 0; s < 4; s++) begin
                if (m_v[s] && (s == e_hit || age(m_rob[s]) > age(int'(mispredict_robid)))) nv[s] = 1'b0;
            end
            m_rest     = 1'b1;
            m_ridx     = e_hit;
            m_row      = 0;
            m_rest_rob = int'(mispredict_robid);
            m_mp_cnt++;
        end else if (m_rest) begin
            m_row++;
            if (m_row == 4) begin
                m_rest = 1'b0;
                m_row  = 0;
            end
        end
        if (e_alloc) begin
            for (int i = 0; i < 2; i++) begin
                if (br_val_id[i]) begin
                    nv[e_slot[i]]    = 1'b1;
                    m_rob[e_slot[i]] = (int'(rob_is_ptr) + i) & 31;
                end
            end
        end
        for (int s = 0; s < 4; s++) m_v[s] = nv[s];
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        rob_is_ptr   = '0;
        rob_head_ptr = '0;
        idle_in();
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free", ckpt_free_cnt, 4);
        chk("rst_rwe", restore_we, 0);
        chk("rst_stall", rename_stall, 0);
        chk("rst_we", ckpt_save_we, 0);
        chk("rst_miss", mispredict_miss, 0);
        rst = 1'b0;

        // Two lanes into an empty table.
        br_val_id = 2'b11; rob_is_ptr = 5'd5;
        step();
        chk("t1_we", s_we, 2'b11);
        chk("t1_idx", s_idx, 4'b0100);
        idle_in();
        step();
        chk("t1_free", s_free, 2);

        // Fill to one free slot, then a two-lane request must stall.
        br_val_id = 2'b01; rob_is_ptr = 5'd7;
        step();
        br_val_id = 2'b11; rob_is_ptr = 5'd9;
        step();
        chk("t2_we", s_we, 2'b00);
        chk("t2_stall", s_stall, 1);
        ret_br_val = 2'b01; robid_ret = {5'd0, 5'd5};
        step();
        chk("t2_stall_same", s_stall, 1);
        ret_br_val = 2'b00;
        step();
        chk("t2_we_grant", s_we, 2'b11);
        chk("t2_idx_grant", s_idx, 4'b1100);
        idle_in();
        ret_br_val = 2'b11; robid_ret = {5'd10, 5'd6};
        step();
        idle_in();
        br_val_id = 2'b01; rob_is_ptr = 5'd3;
        step();

        // Slots hold 9,3,7; mispredict on 7 with head 2.
        idle_in();
        rob_head_ptr = 5'd2;
        mispredict_val = 1'b1; mispredict_robid = 5'd7;
        step();
        chk("t3_miss", s_miss, 0);
        idle_in();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t3_rwe", s_rwe, 1);
            chk("t3_ridx", s_ridx, 2);
            chk("t3_base", s_rbase, c * 8);
        end
        step();
        chk("t3_rwe_end", s_rwe, 0);
        chk("t3_stall_end", s_stall, 0);
        chk("t3_free", s_free, 3);

        // Nested: restore for 9 is overtaken by older 3, then younger 12 misses.
        br_val_id = 2'b01; rob_is_ptr = 5'd9;
        step();
        idle_in();
        mispredict_val = 1'b1; mispredict_robid = 5'd9;
        step();
        idle_in();
        step();
        chk("t4_base0", s_rbase, 0);
        mispredict_val = 1'b1; mispredict_robid = 5'd3;
        step();
        chk("t4_nest_miss", s_miss, 0);
        chk("t4_nest_base", s_rbase, 8);
        idle_in();
        step();
        chk("t4_restart_base", s_rbase, 0);
        chk("t4_restart_idx", s_ridx, 1);
        mispredict_val = 1'b1; mispredict_robid = 5'd12;
        step();
        chk("t4_young_miss", s_miss, 1);
        chk("t4_young_base", s_rbase, 8);
        idle_in();
        repeat (3) step();
        chk("t4_done", s_rwe, 0);

        // ROB id wrap: head 30, slots 31 and 1.
        rob_head_ptr = 5'd30;
        br_val_id = 2'b01; rob_is_ptr = 5'd31;
        step();
        rob_is_ptr = 5'd1;
        step();
        idle_in();
        mispredict_val = 1'b1; mispredict_robid = 5'd31;
        step();
        idle_in();
        step();
        chk("t5_free", s_free, 4);
        repeat (4) step();

        // Asynchronous reset in the middle of a restore.
        rob_head_ptr = 5'd0;
        br_val_id = 2'b01; rob_is_ptr = 5'd4;
        step();
        idle_in();
        mispredict_val = 1'b1; mispredict_robid = 5'd4;
        step();
        idle_in();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rwe", restore_we, 0);
        chk("t6_stall", rename_stall, 0);
        chk("t6_free", ckpt_free_cnt, 4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            idle_in();
            br_val_id    = ($urandom_range(0, 9) < 6) ? 2'($urandom) : 2'b00;
            rob_is_ptr   = 5'($urandom);
            rob_head_ptr = 5'($urandom);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 9) < 3) begin
                    ret_br_val[k]      = 1'b1;
                    robid_ret[k*5 +: 5] = 5'(m_rob[$urandom_range(0, 3)]);
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                mispredict_val   = 1'b1;
                mispredict_robid = ($urandom_range(0, 1) == 0) ? 5'(m_rob[$urandom_range(0, 3)])
                                                                : 5'($urandom);
            end
            step();
        end

`ifdef BRATCR_STATS_EN
        idle_in();
        @(negedge clk);
        chk("stat_stall", stat_stall_cycles, m_stall_cnt);
        chk("stat_mp", stat_mispredicts, m_mp_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bratcr_ctrl.md
Name: bratcr_ctrl

Overview:
Controller for the branch RAT copy registers (BRATCR) that sit beside the front-end RAT.
- Allocates a checkpoint slot to each branch renamed in ID and drives the save strobes that snapshot the FRAT.
- Frees slots when branches retire.
- On a mispredict, squashes younger slots and sequences a multi-cycle restore of the FRAT from the mispredicted branch's copy, stalling rename meanwhile.

Parameters:
ISSUE_WIDTH_MAX, 2, rename lanes per cycle
ROB_MAX_RETIRE, 2, retire lanes per cycle
BRATCR_NUM_ETY, 4, checkpoint slots
ROB_SIZE_CLOG, 5, ROB id width
RAT_SIZE, 32, architectural registers
RESTORE_ROWS_PER_CYC, 8, RAT rows copied per restore cycle; must divide RAT_SIZE

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
br_val_id  in  ISSUE_WIDTH_MAX  lane i is a valid branch in ID
rob_is_ptr  in  ROB_SIZE_CLOG  ROB id of lane 0
rob_head_ptr  in  ROB_SIZE_CLOG  oldest ROB entry; age reference
ret_br_val  in  ROB_MAX_RETIRE  retiring branch valid
robid_ret  in  ROB_MAX_RETIRE*ROB_SIZE_CLOG  retiring ROB ids
mispredict_val  in  1  branch mispredict resolved
mispredict_robid  in  ROB_SIZE_CLOG  ROB id of the mispredicted branch
ckpt_save_we  out  ISSUE_WIDTH_MAX  snapshot FRAT into a slot
ckpt_save_idx  out  ISSUE_WIDTH_MAX*clog2(BRATCR_NUM_ETY)  slot index per lane
restore_we  out  1  FRAT restore-write strobe
restore_idx  out  clog2(BRATCR_NUM_ETY)  source slot
restore_row_base  out  clog2(RAT_SIZE)  first RAT row for this cycle
rename_stall  out  1  hold the ID stage
ckpt_free_cnt  out  clog2(BRATCR_NUM_ETY)+1  free slot count
mispredict_miss  out  1  pulse: mispredict robid matches no valid slot

Behaviour:
Reset:
- All slot valids cleared, FSM in IDLE, restore counter 0.
- All outputs 0, except ckpt_free_cnt = BRATCR_NUM_ETY.
- Reset asserted during RESTORE aborts it immediately.

Slot state:
- Per slot: valid bit and robid register.

Allocation (combinational grant, state update at posedge):
- Conditions: FSM is IDLE, mispredict_val is 0, and the number of valid requesting lanes ≤ free slots.
- Lanes are granted in order to the lowest-index free slots.
- ckpt_save_we[i] = br_val_id[i]. The slot's robid is set to rob_is_ptr+i (mod 2^ROB_SIZE_CLOG).
- If there are too few free slots: all-or-nothing. No grants, rename_stall = 1.
- Free/valid status is taken from registered state only, so a slot freed this cycle is not reallocatable until the next cycle.

Free:
- A valid slot whose robid equals a valid robid_ret[k] is cleared at the next edge.

Mispredict, in IDLE:
- Age(x) = x - rob_head_ptr (mod ROB size).
- Look up the slot matching mispredict_robid. If found:
  - clear that slot and every valid slot with age greater than it;
  - latch its index;
  - FSM goes to RESTORE and the counter is cleared.
- If no slot matches: mispredict_miss = 1 for one cycle and the FSM stays IDLE.
- mispredict_val has priority over same-cycle allocation (allocation is dropped) and over retire-free of the same slot.

RESTORE:
- Lasts RAT_SIZE/RESTORE_ROWS_PER_CYC cycles.
- Each cycle: restore_we = 1, restore_idx = latched slot, restore_row_base = cnt*RESTORE_ROWS_PER_CYC; cnt increments.
- rename_stall = 1 throughout.
- After the last row the FSM returns to IDLE. rename_stall drops the cycle after the final restore_we.
- Retire frees continue during RESTORE.

Mispredict during RESTORE:
- Checkpoint data is read from the slot register latched at mispredict.
- If the new branch is older than the one being restored and has a matching slot: clear that slot and everything younger, relatch the index, and restart the counter at 0.
- If it is younger: ignore it (its slot was already squashed, so it raises mispredict_miss).

ckpt_free_cnt is the registered popcount of ~valid.

Optional Feature:
BRATCR_STATS_EN
- Defined: adds output stat_stall_cycles (32b, saturating), counting cycles with rename_stall = 1, and output stat_mispredicts (16b, saturating), counting accepted mispredicts. Both reset to 0.
- Undefined: neither counter nor port exists, and behaviour is otherwise identical.

Decomposition:
Shared package (rtl_constants): BRATCR_NUM_ETY, BRATCR_NUM_ETY_CLOG, RESTORE_ROWS_PER_CYC, and the FSM enum bratcr_fsm_e {IDLE, RESTORE}.
One sub-module: bratcr_age_cmp, a wrap-around ROB age comparator (robid_a, robid_b, head → a_younger), instantiated per slot.

Test Plan:
1. Alloc: 4 slots free, br_val_id=2'b11, rob_is_ptr=5 → ckpt_save_idx={1,0}, slot robids 5,6, ckpt_free_cnt=2 next cycle.
2. Full: 1 slot free, br_val_id=2'b11 → no save_we, rename_stall=1. Retire robid of one slot → next cycle both lanes granted.
3. Mispredict: slots hold robids 3,7,9, head=2, mispredict_robid=7 → slots 7 and 9 cleared; restore_we high 4 cycles with row_base 0,8,16,24; rename_stall low in cycle 5.
4. Nested mispredict: during RESTORE for robid 9, mispredict robid 3 → counter restarts, restore_idx=slot(3), 4 more cycles. Later mispredict robid 12 → mispredict_miss pulse, restore unaffected.
5. Wrap: head=30, slots robids 31 and 1, mispredict robid 31 → robid 1 judged younger and cleared.
6. Reset: assert rst mid-RESTORE (cycle 2) → restore_we and rename_stall drop asynchronously, ckpt_free_cnt=4.
